// File: rtl/acc_seq8_pkg.sv
// acc_seq8_pkg: shared state encoding and saturation limits for the accumulation stage
package acc_seq8_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
  localparam logic signed [7:0] SAT_POS = 8'sh7F;
  localparam logic signed [7:0] SAT_NEG = 8'sh80;
endpackage

// File: rtl/acc_seq8_ctrl.sv
// acc_seq8_ctrl: sequencing FSM and beat counter for acc_seq8
module acc_seq8_ctrl
  import acc_seq8_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             launch,
  output logic             accept,
  output logic             finish,
  output logic [CNT_W-1:0] cnt_next
);
  acc_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign launch    = (state_q == IDLE) & start;
  assign accept    = in_ready_q & in_valid;
  assign cnt_next  = cnt_q + 1'b1;
  assign finish    = accept & (in_last | (cnt_next == CNT_W'(MAX_LEN)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q    <= ACCUM;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
        end
        ACCUM: if (accept) begin
          cnt_q <= cnt_next;
          if (finish) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/acc_seq8.sv
// acc_seq8: signed byte accumulator driving an external somador adder.
// Define ACC_SAT_EN to saturate the running sum on overflow instead of wrapping.
module acc_seq8
  import acc_seq8_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [7:0]       add_s,
  input  logic             add_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  logic [7:0]       acc_q, acc_d, out_sum_q;
  logic             ovf_q, ovf_d, out_ovf_q;
  logic [CNT_W-1:0] out_count_q, cnt_next;
  logic             launch, accept, finish;
  acc_seq8_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_last(in_last),
    .out_ready(out_ready), .in_ready(in_ready), .out_valid(out_valid), .launch(launch),
    .accept(accept), .finish(finish), .cnt_next(cnt_next)
  );
  assign add_a     = acc_q;
  assign add_b     = in_ready ? in_data : 8'h00;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
  always_comb begin
    acc_d = launch ? 8'h00 : accept ? add_s : acc_q;
`ifdef ACC_SAT_EN
    if (accept && !add_flag) acc_d = in_data[7] ? SAT_NEG : SAT_POS;
`endif
    ovf_d = launch ? 1'b0 : ovf_q | (accept & ~add_flag);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      if (finish) begin
        out_sum_q   <= acc_d;
        out_ovf_q   <= ovf_d;
        out_count_q <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_acc_seq8.sv
// tb_acc_seq8: directed self-checking bench for acc_seq8 with a behavioural somador model
module tb_acc_seq8;
  localparam int CNT_W = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [7:0] in_data = 0;
  logic in_ready, out_valid, out_ovf, add_flag;
  logic [7:0] add_a, add_b, add_s, out_sum;
  logic [CNT_W-1:0] out_count;
  int checks = 0, failures = 0;

  acc_seq8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .add_flag(add_flag), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  // somador: flag=1 means no signed overflow
  assign add_s    = add_a + add_b;
  assign add_flag = !((add_a[7] == add_b[7]) && (add_s[7] != add_a[7]));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    in_valid = 1; in_data = d; in_last = last;
    step();
    in_valid = 0; in_last = 0;
  endtask

  task automatic result(input string tag, input logic [7:0] s, input logic o, input logic [CNT_W-1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"}, 32'(out_sum), 32'(s));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_rdy"}, 32'(in_ready), 0);
  endtask

  initial begin
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_out_count", 32'(out_count), 0);
    rst_n = 1;
    step();
    chk("idle_add_b", 32'(add_b), 0);

    go();
    chk("accum_ready", 32'(in_ready), 1);
    in_data = 8'd10;
    #1 chk("accum_add_b", 32'(add_b), 32'd10);
    beat(8'd10, 0);
    beat(8'd20, 0);
    step();
    chk("hold_add_a", 32'(add_a), 32'd30);
    chk("hold_valid", 32'(out_valid), 0);
    beat(8'd30, 1);
    result("seq60", 8'd60, 0, 3);
    step();
    chk("seq60_idle_valid", 32'(out_valid), 0);
    chk("seq60_retain_sum", 32'(out_sum), 32'd60);

    go();
    beat(8'd100, 0);
    beat(8'd50, 1);
`ifdef ACC_SAT_EN
    result("pos_ovf", 8'h7F, 1, 2);
`else
    result("pos_ovf", 8'h96, 1, 2);
`endif
    step();

    go();
    beat(8'h9C, 0);
    beat(8'hCE, 1);
`ifdef ACC_SAT_EN
    result("neg_ovf", 8'h80, 1, 2);
`else
    result("neg_ovf", 8'h6A, 1, 2);
`endif
    step();

    go();
    for (int i = 0; i < 15; i++) beat(8'd1, 0);
    chk("max_not_done", 32'(out_valid), 0);
    out_ready = 0;
    beat(8'd1, 0);
    result("maxlen", 8'd16, 0, 16);

    in_valid = 1; in_data = 8'd7; start = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      result("bp", 8'd16, 0, 16);
    end
    out_ready = 1;
    step();
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 0);
    start = 0; in_valid = 0;
    step();
    chk("bp_start_ignored", 32'(in_ready), 0);

    go();
    beat(8'd7, 0);
    beat(8'd8, 0);
    chk("mid_add_a", 32'(add_a), 32'd15);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_sum", 32'(out_sum), 0);
    chk("mid_rst_count", 32'(out_count), 0);
    chk("mid_rst_add_a", 32'(add_a), 0);
    step();
    rst_n = 1;
    step();
    go();
    beat(8'd5, 1);
    result("after_rst", 8'd5, 0, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
